// File: rtl/slice_run_ctrl_if.sv
// rtl/slice_run_ctrl_if.sv - key, slice-handshake and status bundle for slice_run_ctrl
interface slice_run_ctrl_if;
  logic       key_start_n;
  logic       key_pause_n;
  logic       cut_ack_i;
  logic       start_o;
  logic       pause_o;
  logic       finish_o;
  logic       cut_req_o;
  logic [4:0] slice_num_o;
  logic [1:0] state_o;

  modport master (
    output key_start_n, key_pause_n, cut_ack_i,
    input  start_o, pause_o, finish_o, cut_req_o, slice_num_o, state_o
  );

  modport slave (
    input  key_start_n, key_pause_n, cut_ack_i,
    output start_o, pause_o, finish_o, cut_req_o, slice_num_o, state_o
  );
endinterface

// File: rtl/slice_run_ctrl.sv
// rtl/slice_run_ctrl.sv - start/pause key conditioning and slice-run state machine
// Key debounce is compiled in only when SLICE_CTRL_DEBOUNCE_EN is defined.
module slice_run_ctrl #(
  parameter int DEB_CYCLES = 50000,
  parameter int SLICE_MAX  = 16
) (
  input logic               clk,
  input logic               rst_n,
  slice_run_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [4:0] SMAX = 5'(SLICE_MAX);

  logic [1:0] key_raw;
  logic [1:0] ev;
  logic [1:0] sync_fill;

  assign key_raw = {bus.key_pause_n, bus.key_start_n};

  // Marks when the synchronizers hold real key samples rather than reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_fill <= 2'b00;
    end else begin
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

`ifdef SLICE_CTRL_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
`else
  wire unused_deb_cycles = ^DEB_CYCLES;
`endif

  for (genvar k = 0; k < 2; k++) begin : g_key
    logic s1;
    logic s2;
    logic lvl;
    logic lvl_q;
    logic armed;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1 <= 1'b1;
        s2 <= 1'b1;
      end else begin
        s1 <= key_raw[k];
        s2 <= s1;
      end
    end

`ifdef SLICE_CTRL_DEBOUNCE_EN
    logic [CNT_W-1:0] deb_cnt;
    logic             deb;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        deb_cnt <= '0;
        deb     <= 1'b1;
      end else if (s2 != deb) begin
        if (deb_cnt == CNT_W'(DEB_CYCLES - 1)) begin
          deb     <= s2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end

    assign lvl = deb;
`else
    assign lvl = s2;
`endif

    // A key held through reset stays unarmed until it is seen released.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lvl_q <= 1'b1;
        armed <= 1'b0;
      end else begin
        lvl_q <= lvl;
        if (sync_fill[1] && s2 && lvl) begin
          armed <= 1'b1;
        end
      end
    end

    assign ev[k] = armed & lvl_q & ~lvl;
  end

  logic start_ev;
  logic pause_ev;
  assign start_ev = ev[0];
  assign pause_ev = ev[1];

  state_t     state_q;
  state_t     state_d;
  logic [4:0] cnt_q;
  logic [4:0] cnt_d;
  logic       start_r;
  logic       pause_r;
  logic       finish_r;
  logic       cut_r;
  logic       start_d;
  logic       pause_d;
  logic       finish_d;
  logic       cut_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      start_r  <= 1'b0;
      pause_r  <= 1'b0;
      finish_r <= 1'b0;
      cut_r    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      start_r  <= start_d;
      pause_r  <= pause_d;
      finish_r <= finish_d;
      cut_r    <= cut_d;
    end
  end

  // An ack that completes the run takes priority over a same-cycle pause.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_ev) begin
          state_d = RUN;
        end
      end
      RUN, PAUSE: begin
        if (bus.cut_ack_i) begin
          cnt_d = cnt_q + 5'd1;
        end
        if (bus.cut_ack_i && ((cnt_q + 5'd1) == SMAX)) begin
          state_d = DONE;
        end else if (pause_ev) begin
          state_d = (state_q == RUN) ? PAUSE : RUN;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    start_d  = (state_q == IDLE) && (state_d == RUN);
    pause_d  = ((state_q == RUN) && (state_d == PAUSE)) ||
               ((state_q == PAUSE) && (state_d == RUN));
    finish_d = (state_d == DONE);
    cut_d    = (state_d == RUN);
  end

  assign bus.start_o     = start_r;
  assign bus.pause_o     = pause_r;
  assign bus.finish_o    = finish_r;
  assign bus.cut_req_o   = cut_r;
  assign bus.slice_num_o = cnt_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_slice_run_ctrl.sv
// tb/tb_slice_run_ctrl.sv - directed scoreboard bench for slice_run_ctrl
module tb_slice_run_ctrl;
  localparam int DEB  = 4;
  localparam int SMAX = 16;
`ifdef SLICE_CTRL_DEBOUNCE_EN
  localparam int EV_LAT = 3 + DEB;
`else
  localparam int EV_LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  slice_run_ctrl_if bus();

  slice_run_ctrl #(.DEB_CYCLES(DEB), .SLICE_MAX(SMAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   n_start = 0;
  int   n_pause = 0;
  bit   seen;

  always @(negedge clk) begin
    if (bus.start_o === 1'b1) n_start++;
    if (bus.pause_o === 1'b1) n_pause++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input int v);
    sb.push_back('{tag, v});
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === 32'(e.val)) else begin
        n_err++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic wait_pulse(input bit which, output bit got);
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if ((which ? bus.pause_o : bus.start_o) === 1'b1) got = 1'b1;
    end
  endtask

  task automatic ack();
    bus.cut_ack_i = 1'b1;
    tick();
    bus.cut_ack_i = 1'b0;
  endtask

  task automatic check_outputs(input string t, input int st, input int sl,
                               input int fin, input int cut);
    push({t, "_state"}, st);
    push({t, "_slice"}, sl);
    push({t, "_finish"}, fin);
    push({t, "_cut_req"}, cut);
    pop_cmp(32'(bus.state_o));
    pop_cmp(32'(bus.slice_num_o));
    pop_cmp(32'(bus.finish_o));
    pop_cmp(32'(bus.cut_req_o));
  endtask

  task automatic release_settle(input bit which);
    tick(8);
    if (which) bus.key_pause_n = 1'b1;
    else       bus.key_start_n = 1'b1;
    tick(DEB + 12);
  endtask

  initial begin
    bus.key_start_n = 1'b1;
    bus.key_pause_n = 1'b1;
    bus.cut_ack_i   = 1'b0;
    rst_n           = 1'b0;
    tick(3);
    check_outputs("reset", 0, 0, 0, 0);
    push("reset_start_o", 0);
    push("reset_pause_o", 0);
    pop_cmp(32'(bus.start_o));
    pop_cmp(32'(bus.pause_o));

    rst_n = 1'b1;
    tick(5);

    bus.key_start_n = 1'b0;
    push("start_seen", 1);
    wait_pulse(1'b0, seen);
    pop_cmp(32'(seen));
    check_outputs("start", 1, 0, 0, 1);
    release_settle(1'b0);
    push("start_once", 1);
    pop_cmp(n_start);

`ifdef SLICE_CTRL_DEBOUNCE_EN
    bus.key_pause_n = 1'b0;
    tick(3);
    bus.key_pause_n = 1'b1;
    tick(DEB + 12);
    push("glitch_pause_count", 0);
    pop_cmp(n_pause);
    check_outputs("glitch", 1, 0, 0, 1);
`endif

    bus.key_pause_n = 1'b0;
    push("pause1_seen", 1);
    wait_pulse(1'b1, seen);
    pop_cmp(32'(seen));
    check_outputs("pause1", 2, 0, 0, 0);
    release_settle(1'b1);

    ack();
    check_outputs("paused_ack", 2, 1, 0, 0);

    bus.key_pause_n = 1'b0;
    push("pause2_seen", 1);
    wait_pulse(1'b1, seen);
    pop_cmp(32'(seen));
    check_outputs("resume", 1, 1, 0, 1);
    release_settle(1'b1);
    push("pause_pulses", 2);
    pop_cmp(n_pause);

    for (int i = 2; i <= SMAX - 1; i++) begin
      push("ack_slice", i);
      ack();
      pop_cmp(32'(bus.slice_num_o));
    end
    check_outputs("slice15", 1, 15, 0, 1);

    // Land the final ack on the same cycle as the pause press event.
    bus.key_pause_n = 1'b0;
    tick(EV_LAT - 1);
    ack();
    check_outputs("coincident", 3, 16, 1, 0);
    release_settle(1'b1);
    push("coincident_no_pause", 2);
    pop_cmp(n_pause);

    ack();
    check_outputs("ack17", 3, 16, 1, 0);

    bus.key_start_n = 1'b0;
    release_settle(1'b0);
    bus.key_pause_n = 1'b0;
    release_settle(1'b1);
    check_outputs("done_keys", 3, 16, 1, 0);
    push("done_start_count", 1);
    pop_cmp(n_start);

    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    bus.key_start_n = 1'b0;
    push("restart_seen", 1);
    wait_pulse(1'b0, seen);
    pop_cmp(32'(seen));
    release_settle(1'b0);
    bus.key_pause_n = 1'b0;
    push("pause3_seen", 1);
    wait_pulse(1'b1, seen);
    pop_cmp(32'(seen));
    release_settle(1'b1);
    repeat (7) ack();
    check_outputs("pause7", 2, 7, 0, 0);

    bus.key_start_n = 1'b0;
    tick(2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_reset", 0, 0, 0, 0);
    push("async_reset_start_o", 0);
    push("async_reset_pause_o", 0);
    pop_cmp(32'(bus.start_o));
    pop_cmp(32'(bus.pause_o));

    tick(3);
    rst_n = 1'b1;
    tick(25);
    check_outputs("held_through_reset", 0, 0, 0, 0);
    push("held_start_count", 2);
    pop_cmp(n_start);

    bus.key_start_n = 1'b1;
    tick(DEB + 12);
    bus.key_start_n = 1'b0;
    push("repress_seen", 1);
    wait_pulse(1'b0, seen);
    pop_cmp(32'(seen));
    check_outputs("repress", 1, 0, 0, 1);
    release_settle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/slice_run_ctrl.md
SLICE_RUN_CTRL -- requirements
Module: slice_run_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 50000, meaning cycles a key must be stable to be accepted (1 ms at 50 MHz).
REQ-002 SHALL have parameter SLICE_MAX, default 16, meaning slice count at which the run completes (range 1..31).
REQ-003 SHALL have port clk  input  1  single system clock, all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port key_start_n  input  1  raw start push-button, active-low, asynchronous to clk.
REQ-006 SHALL have port key_pause_n  input  1  raw pause push-button, active-low, asynchronous to clk.
REQ-007 SHALL have port cut_ack_i  input  1  datapath one-cycle pulse: one slice completed.
REQ-008 SHALL have port start_o  output  1  one-cycle pulse to display decoder start input.
REQ-009 SHALL have port pause_o  output  1  one-cycle pulse to display decoder pause (toggle) input.
REQ-010 SHALL have port finish_o  output  1  level, high in DONE.
REQ-011 SHALL have port cut_req_o  output  1  level, datapath may cut while high.
REQ-012 SHALL have port slice_num_o  output  5  completed slices, 0..SLICE_MAX.
REQ-013 SHALL have port state_o  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

Function
REQ-014 Each key SHALL pass a 2-flop synchronizer before any other logic.
REQ-015 Debounced key level SHALL change only after the synchronized level differs from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-016 A press event SHALL be a one-cycle pulse on the debounced high-to-low transition; holding a key yields exactly one event.
REQ-017 All outputs SHALL be registered; state change and its start_o/pause_o pulse SHALL appear in the cycle after the press event.
REQ-018 IDLE: start event -> RUN, start_o=1 for one cycle; pause event ignored; cut_req_o=0.
REQ-019 RUN: cut_req_o=1; each cut_ack_i pulse increments slice_num_o by 1.
REQ-020 RUN: increment reaching SLICE_MAX -> DONE, cut_req_o=0 in the same cycle finish_o rises.
REQ-021 RUN: pause event -> PAUSE, pause_o=1 for one cycle; start event ignored.
REQ-022 PAUSE: cut_req_o=0; cut_ack_i still counted (in-flight slice); reaching SLICE_MAX -> DONE.
REQ-023 PAUSE: pause event -> RUN, pause_o=1 for one cycle.
REQ-024 DONE: sticky until reset; all key events ignored; finish_o=1, slice_num_o holds SLICE_MAX.
REQ-025 slice_num_o SHALL saturate at SLICE_MAX; cut_ack_i in IDLE/DONE ignored.
REQ-026 Simultaneous start and pause events in IDLE: start wins, pause discarded.
REQ-027 cut_ack_i and pause event same cycle in RUN: ack counted first; if count reaches SLICE_MAX -> DONE and no pause_o, else -> PAUSE with pause_o.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, slice_num_o=0, start_o=pause_o=finish_o=cut_req_o=0, debounce counters 0, debounced levels released (high).
REQ-029 Reset mid-RUN/PAUSE SHALL abandon the run without emitting any pulse; a key held across reset release SHALL NOT produce an event until released and pressed again.

Configuration
REQ-030 With SLICE_CTRL_DEBOUNCE_EN defined, debounce per REQ-015 SHALL be compiled in.
REQ-031 Without SLICE_CTRL_DEBOUNCE_EN, synchronized key level SHALL feed edge detection directly (no counter, DEB_CYCLES unused); all other behaviour identical.

Verification (DEB_CYCLES=4, SLICE_MAX=16, macro defined unless noted)
REQ-032 Start key low 10 cycles -> one start_o pulse, state_o=1, cut_req_o=1; 3-cycle glitch -> no event.
REQ-033 RUN, 16 cut_ack_i pulses -> slice_num_o 1..16, on 16th state_o=3, finish_o=1, cut_req_o=0; 17th ack -> stays 16.
REQ-034 RUN, pause press, 1 ack, pause press -> pause_o twice, state 1->2->1, slice_num_o +1, cut_req_o low only in PAUSE.
REQ-035 slice_num_o=15, ack coincident with pause event -> state_o=3, no pause_o.
REQ-036 rst_n low during PAUSE with slice_num_o=7 -> all outputs 0 same cycle; start held through release -> stays IDLE.
REQ-037 Macro undefined: start key low 1 synchronized cycle -> start_o pulse 1 cycle later.
